calc_entry_ctrl: RTL and testbench

Sequencer between the PS/2 byte receiver and the arithmetic unit of the keypad calculator. It consumes raw received bytes and filters break codes, extended prefixes and typematic repeats. It then decodes numpad keys into digit, operator, Enter and Escape tokens. An entry state machine assembles two decimal operands, issues a req/ack transaction to the ALU and holds the value to be shown on the display.

---
 rtl/calc_entry_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
// Sits between the PS/2 byte receiver and the calculator ALU. Raw scan-code
// bytes are filtered (break codes, E0 prefixes, typematic repeats) and
// decoded into digit/operator/Enter/Escape tokens. An entry state machine
// builds two decimal operands, runs a req/ack transaction with the ALU and
// holds the value shown on the display.
module calc_entry_ctrl #(
    parameter int W      = 16,
    parameter int DIGITS = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    input  logic         byte_err,
    output logic         alu_req,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [1:0]   op_sel,
    input  logic         alu_ack,
    input  logic [W-1:0] alu_result,
    input  logic         alu_fault,
    output logic [W-1:0] disp_val,
    output logic         disp_err,
    output logic         busy
);

    // Digit counters must be able to hold DIGITS itself (the "full" marker
    // used after a result is loaded).
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        TK_DIGIT = 2'd0,
        TK_OP    = 2'd1,
        TK_ENTER = 2'd2,
        TK_ESC   = 2'd3
    } tok_kind_t;

    typedef enum logic [2:0] {
        ENT_A = 3'd0,
        ENT_B = 3'd1,
        REQ   = 3'd2,
        SHOW  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Filter state
    logic       brk, brk_n;
    logic       ext, ext_n;
    logic [7:0] last_make, last_make_n;

    // Scan-code decode result for the current byte
    logic       map_hit;
    tok_kind_t  map_kind;
    logic [3:0] map_val;
    logic       emit;

    // Registered token handed to the FSM one edge later
    logic       tok_vld;
    tok_kind_t  tok_kind;
    logic [3:0] tok_val;

    // Entry state machine registers
    state_t        state, state_n;
    logic [W-1:0]  a, a_n;
    logic [W-1:0]  b, b_n;
    logic [CW-1:0] na, na_n;
    logic [CW-1:0] nb, nb_n;
    logic [1:0]    op, op_n;

    // x*10 + d with shifts, wrapping to W bits
    function automatic logic [W-1:0] mac10(input logic [W-1:0] x, input logic [3:0] d);
        logic [W-1:0] x8;
        logic [W-1:0] x2;
        x8 = x << 3;
        x2 = x << 1;
        return x8 + x2 + W'(d);
    endfunction

    // Map numpad scan codes to token kind and value (digit or operator code)
    always_comb begin
        map_hit  = 1'b1;
        map_kind = TK_DIGIT;
        map_val  = 4'd0;
        case (byte_data)
            8'h70: map_val = 4'd0;
            8'h69: map_val = 4'd1;
            8'h72: map_val = 4'd2;
            8'h7A: map_val = 4'd3;
            8'h6B: map_val = 4'd4;
            8'h73: map_val = 4'd5;
            8'h74: map_val = 4'd6;
            8'h6C: map_val = 4'd7;
            8'h75: map_val = 4'd8;
            8'h7D: map_val = 4'd9;
            8'h79: begin map_kind = TK_OP; map_val = 4'd0; end
            8'h7B: begin map_kind = TK_OP; map_val = 4'd1; end
            8'h7C: begin map_kind = TK_OP; map_val = 4'd2; end
            8'h4A: begin map_kind = TK_OP; map_val = 4'd3; end
            8'h5A: map_kind = TK_ENTER;
            8'h76: map_kind = TK_ESC;
            default: map_hit = 1'b0;
        endcase
    end

    // Byte filter: track break/extended prefixes and drop typematic repeats
    always_comb begin
        brk_n       = brk;
        ext_n       = ext;
        last_make_n = last_make;
        emit        = 1'b0;
        if (byte_valid) begin
            if (byte_err) begin
                brk_n = 1'b0;
                ext_n = 1'b0;
            end else if (byte_data == 8'hF0) begin
                brk_n = 1'b1;
            end else if (byte_data == 8'hE0) begin
                ext_n = 1'b1;
            end else begin
                brk_n = 1'b0;
                ext_n = 1'b0;
                if (brk) begin
                    if (byte_data == last_make) begin
                        last_make_n = 8'h00;
                    end
                end else if (ext && (byte_data != 8'h4A) && (byte_data != 8'h5A)) begin
                    emit = 1'b0;
                end else if (byte_data != last_make) begin
                    last_make_n = byte_data;
                    emit        = map_hit;
                end
            end
        end
    end

    // Filter flags and the token register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            brk       <= 1'b0;
            ext       <= 1'b0;
            last_make <= 8'h00;
            tok_vld   <= 1'b0;
            tok_kind  <= TK_DIGIT;
            tok_val   <= 4'd0;
        end else begin
            brk       <= brk_n;
            ext       <= ext_n;
            last_make <= last_make_n;
            tok_vld   <= emit;
            tok_kind  <= map_kind;
            tok_val   <= map_val;
        end
    end

    // Entry FSM: next state and operand updates
    always_comb begin
        state_n = state;
        a_n     = a;
        b_n     = b;
        na_n    = na;
        nb_n    = nb;
        op_n    = op;
        case (state)
            ENT_A: begin
                if (tok_vld) begin
                    case (tok_kind)
                        TK_DIGIT: begin
                            if (na < CW'(DIGITS)) begin
                                a_n  = mac10(a, tok_val);
                                na_n = na + CW'(1);
                            end
                        end
                        TK_OP: begin
                            op_n    = tok_val[1:0];
                            b_n     = '0;
                            nb_n    = '0;
                            state_n = ENT_B;
                        end
                        TK_ESC: begin
                            a_n  = '0;
                            na_n = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ENT_B: begin
                if (tok_vld) begin
                    case (tok_kind)
                        TK_DIGIT: begin
                            if (nb < CW'(DIGITS)) begin
                                b_n  = mac10(b, tok_val);
                                nb_n = nb + CW'(1);
                            end
                        end
                        TK_OP: begin
                            if (nb == '0) begin
                                op_n = tok_val[1:0];
                            end
                        end
                        TK_ENTER: begin
                            if (nb != '0) begin
                                state_n = REQ;
                            end
                        end
                        TK_ESC: begin
                            a_n     = '0;
                            b_n     = '0;
                            na_n    = '0;
                            nb_n    = '0;
                            op_n    = 2'd0;
                            state_n = ENT_A;
                        end
                        default: ;
                    endcase
                end
            end
            REQ: begin
                if (alu_ack) begin
                    if (alu_fault) begin
                        state_n = ERR;
                    end else begin
                        a_n     = alu_result;
                        na_n    = CW'(DIGITS);
                        state_n = SHOW;
                    end
                end
            end
            SHOW: begin
                if (tok_vld) begin
                    case (tok_kind)
                        TK_DIGIT: begin
                            a_n     = W'(tok_val);
                            na_n    = CW'(1);
                            state_n = ENT_A;
                        end
                        TK_OP: begin
                            op_n    = tok_val[1:0];
                            b_n     = '0;
                            nb_n    = '0;
                            state_n = ENT_B;
                        end
                        TK_ESC: begin
                            a_n     = '0;
                            b_n     = '0;
                            na_n    = '0;
                            nb_n    = '0;
                            op_n    = 2'd0;
                            state_n = ENT_A;
                        end
                        default: ;
                    endcase
                end
            end
            ERR: begin
                if (tok_vld && (tok_kind == TK_ESC)) begin
                    a_n     = '0;
                    b_n     = '0;
                    na_n    = '0;
                    nb_n    = '0;
                    op_n    = 2'd0;
                    state_n = ENT_A;
                end
            end
            default: state_n = ENT_A;
        endcase
    end

    // Entry FSM registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ENT_A;
            a     <= '0;
            b     <= '0;
            na    <= '0;
            nb    <= '0;
            op    <= 2'd0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            na    <= na_n;
            nb    <= nb_n;
            op    <= op_n;
        end
    end

    // Display selection: second operand while it is being typed, blank on error
    always_comb begin
        disp_val = a;
        if (state == ERR) begin
            disp_val = '0;
        end else if ((state == ENT_B) && (nb != '0)) begin
            disp_val = b;
        end
    end

    assign op_a     = a;
    assign op_b     = b;
    assign op_sel   = op;
    assign alu_req  = (state == REQ);
    assign busy     = (state == REQ);
    assign disp_err = (state == ERR);

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl
// Directed scan-code sequences with hand-computed expected display and
// ALU-request values for calc_entry_ctrl.
module tb_calc_entry_ctrl;

    localparam int W      = 16;
    localparam int DIGITS = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b1;
    logic         byte_valid = 1'b0;
    logic [7:0]   byte_data = 8'h00;
    logic         byte_err = 1'b0;
    logic         alu_req;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   op_sel;
    logic         alu_ack = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         alu_fault = 1'b0;
    logic [W-1:0] disp_val;
    logic         disp_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] seq[$];

    calc_entry_ctrl #(.W(W), .DIGITS(DIGITS)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .alu_req    (alu_req),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sel     (op_sel),
        .alu_ack    (alu_ack),
        .alu_result (alu_result),
        .alu_fault  (alu_fault),
        .disp_val   (disp_val),
        .disp_err   (disp_err),
        .busy       (busy)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drive the bytes in seq back to back, then one idle cycle so the FSM acts
    task automatic applyStimulus();
        foreach (seq[i]) begin
            byte_data  = seq[i];
            byte_valid = 1'b1;
            @(negedge CLK);
        end
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        @(negedge CLK);
    endtask

    task automatic sendErrByte(input logic [7:0] value);
        byte_data  = value;
        byte_err   = 1'b1;
        byte_valid = 1'b1;
        @(negedge CLK);
        byte_err   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic pulseAck(input logic [W-1:0] result, input logic fault);
        alu_result = result;
        alu_fault  = fault;
        alu_ack    = 1'b1;
        @(negedge CLK);
        alu_ack    = 1'b0;
        alu_fault  = 1'b0;
    endtask

    initial begin
        $display("[TB] start");
        #1 RST_N = 1'b0;
        #1;
        checkOutput("rst_alu_req", 32'(alu_req), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_disp_val", 32'(disp_val), 0);
        checkOutput("rst_disp_err", 32'(disp_err), 0);
        checkOutput("rst_op_a", 32'(op_a), 0);
        checkOutput("rst_op_sel", 32'(op_sel), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // 12 + 3
        seq = '{8'h69, 8'hF0, 8'h69, 8'h72, 8'hF0, 8'h72};
        applyStimulus();
        checkOutput("add_entry_a", 32'(disp_val), 12);
        seq = '{8'h79, 8'hF0, 8'h79};
        applyStimulus();
        checkOutput("add_disp_nb0", 32'(disp_val), 12);
        seq = '{8'h7A, 8'hF0, 8'h7A};
        applyStimulus();
        checkOutput("add_disp_b", 32'(disp_val), 3);
        seq = '{8'h5A, 8'hF0, 8'h5A};
        applyStimulus();
        checkOutput("add_alu_req", 32'(alu_req), 1);
        checkOutput("add_busy", 32'(busy), 1);
        checkOutput("add_op_a", 32'(op_a), 12);
        checkOutput("add_op_b", 32'(op_b), 3);
        checkOutput("add_op_sel", 32'(op_sel), 0);
        repeat (3) @(negedge CLK);
        checkOutput("add_req_held", 32'(alu_req), 1);
        checkOutput("add_op_a_held", 32'(op_a), 12);
        pulseAck(16'd15, 1'b0);
        checkOutput("add_result", 32'(disp_val), 15);
        checkOutput("add_req_drop", 32'(alu_req), 0);
        checkOutput("add_busy_drop", 32'(busy), 0);
        pulseAck(16'd999, 1'b0);
        checkOutput("idle_ack_ignored", 32'(disp_val), 15);

        // Chain on the result, operator replaced while nb=0
        seq = '{8'h79, 8'hF0, 8'h79, 8'h7C, 8'hF0, 8'h7C};
        applyStimulus();
        checkOutput("chain_op_replace", 32'(op_sel), 2);
        checkOutput("chain_disp", 32'(disp_val), 15);
        seq = '{8'h72, 8'hF0, 8'h72, 8'h5A, 8'hF0, 8'h5A};
        applyStimulus();
        checkOutput("chain_req", 32'(alu_req), 1);
        checkOutput("chain_op_a", 32'(op_a), 15);
        checkOutput("chain_op_b", 32'(op_b), 2);
        checkOutput("chain_op_sel", 32'(op_sel), 2);
        pulseAck(16'd30, 1'b0);
        checkOutput("chain_result", 32'(disp_val), 30);

        // Escape, then typematic and extended handling
        seq = '{8'h76, 8'hF0, 8'h76};
        applyStimulus();
        checkOutput("esc_disp", 32'(disp_val), 0);
        checkOutput("esc_op_sel", 32'(op_sel), 0);
        seq = '{8'h69, 8'h69, 8'h69, 8'hF0, 8'h69};
        applyStimulus();
        checkOutput("typematic", 32'(disp_val), 1);
        seq = '{8'hE0, 8'h75, 8'hF0, 8'h75};
        applyStimulus();
        checkOutput("arrow_dropped", 32'(disp_val), 1);
        seq = '{8'h75};
        applyStimulus();
        checkOutput("after_arrow", 32'(disp_val), 18);
        seq = '{8'hE0, 8'h4A};
        applyStimulus();
        checkOutput("ext_div_op", 32'(op_sel), 3);
        checkOutput("ext_div_disp", 32'(disp_val), 18);
        seq = '{8'h72};
        applyStimulus();
        checkOutput("ext_div_entb", 32'(disp_val), 2);
        seq = '{8'hF0, 8'h72, 8'h76, 8'hF0, 8'h76};
        applyStimulus();
        checkOutput("entb_esc_disp", 32'(disp_val), 0);
        checkOutput("entb_esc_op", 32'(op_sel), 0);

        // Digit limit
        for (int i = 0; i < 5; i++) begin
            seq = '{8'h7D, 8'hF0, 8'h7D};
            applyStimulus();
        end
        checkOutput("digit_limit", 32'(disp_val), 9999);

        // A corrupted byte clears a pending break prefix
        seq = '{8'h76, 8'hF0};
        applyStimulus();
        sendErrByte(8'hF0);
        seq = '{8'h69};
        applyStimulus();
        checkOutput("err_byte_make", 32'(disp_val), 1);
        seq = '{8'hF0, 8'h69};
        applyStimulus();

        // 7 / 0 with ALU fault
        seq = '{8'h76, 8'hF0, 8'h76, 8'h6C, 8'hF0, 8'h6C, 8'h4A, 8'hF0, 8'h4A,
                8'h70, 8'hF0, 8'h70, 8'h5A, 8'hF0, 8'h5A};
        applyStimulus();
        checkOutput("div_req", 32'(alu_req), 1);
        checkOutput("div_op_a", 32'(op_a), 7);
        checkOutput("div_op_b", 32'(op_b), 0);
        checkOutput("div_op_sel", 32'(op_sel), 3);
        pulseAck(16'd5, 1'b1);
        checkOutput("fault_err", 32'(disp_err), 1);
        checkOutput("fault_disp", 32'(disp_val), 0);
        checkOutput("fault_req", 32'(alu_req), 0);
        seq = '{8'h69, 8'hF0, 8'h69, 8'h5A, 8'hF0, 8'h5A};
        applyStimulus();
        checkOutput("fault_digit_ign", 32'(disp_val), 0);
        checkOutput("fault_err_held", 32'(disp_err), 1);
        seq = '{8'h76};
        applyStimulus();
        checkOutput("fault_clear_err", 32'(disp_err), 0);
        checkOutput("fault_clear_disp", 32'(disp_val), 0);
        seq = '{8'hF0, 8'h76};
        applyStimulus();

        // Token landing with the ack is discarded
        seq = '{8'h69, 8'hF0, 8'h69, 8'h79, 8'hF0, 8'h79, 8'h69, 8'hF0, 8'h69,
                8'h5A, 8'hF0, 8'h5A};
        applyStimulus();
        checkOutput("same_cyc_req", 32'(alu_req), 1);
        byte_data  = 8'h72;
        byte_valid = 1'b1;
        @(negedge CLK);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pulseAck(16'd7, 1'b0);
        @(negedge CLK);
        checkOutput("same_cyc_disp", 32'(disp_val), 7);
        checkOutput("same_cyc_req_off", 32'(alu_req), 0);
        seq = '{8'hF0, 8'h72};
        applyStimulus();
        checkOutput("same_cyc_break", 32'(disp_val), 7);

        // Reset during a pending request
        seq = '{8'h72, 8'hF0, 8'h72, 8'h79, 8'hF0, 8'h79, 8'h72, 8'hF0, 8'h72,
                8'h5A, 8'hF0, 8'h5A};
        applyStimulus();
        checkOutput("midreq_req", 32'(alu_req), 1);
        checkOutput("midreq_op_a", 32'(op_a), 2);
        RST_N = 1'b0;
        #1;
        checkOutput("midreq_async_req", 32'(alu_req), 0);
        checkOutput("midreq_async_busy", 32'(busy), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        pulseAck(16'd99, 1'b0);
        checkOutput("late_ack_req", 32'(alu_req), 0);
        checkOutput("late_ack_disp", 32'(disp_val), 0);
        checkOutput("late_ack_op_a", 32'(op_a), 0);
        seq = '{8'h6B, 8'hF0, 8'h6B, 8'h6B, 8'hF0, 8'h6B};
        applyStimulus();
        checkOutput("post_reset_entry", 32'(disp_val), 44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
